// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (truncating, denormals flushed).
// S1 unpacks and aligns, S2 adds or subtracts magnitudes, S3 normalises and packs.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           flags
);

  localparam int W           = 1 + EXP_W + MAN_W;
  localparam int EXT_W       = MAN_W + 4;        // hidden + mantissa + guard/round/sticky
  localparam int MAG_W       = MAN_W + 5;        // EXT_W plus carry-out
  localparam int ALIGN_LIMIT = MAN_W + 3;
  localparam int EXP_MAX     = (1 << EXP_W) - 1;

  localparam logic [3:0] FLAG_NONE      = 4'b0000;
  localparam logic [3:0] FLAG_INVALID   = 4'b1000;
  localparam logic [3:0] FLAG_OVERFLOW  = 4'b0100;
  localparam logic [3:0] FLAG_UNDERFLOW = 4'b0010;
  localparam logic [3:0] FLAG_ZERO      = 4'b0001;

  logic advance;

  // Stage registers
  logic                 s1Valid, s2Valid, s3Valid;
  logic [TAG_W-1:0]     s1Tag, s2Tag, s3Tag;
  logic                 s1Nan, s2Nan;
  logic                 s1BaseSign, s1OtherSign, s2Sign;
  logic [EXP_W-1:0]     s1Exp, s2Exp;
  logic [EXT_W-1:0]     s1BaseMan, s1OtherMan;
  logic [MAG_W-1:0]     s2Mag;
  logic [W-1:0]         s3Result;
  logic [3:0]           s3Flags;

  // Whole pipeline freezes only when the output is held; bubbles are kept.
  assign advance   = !(s3Valid && !out_ready);
  assign in_ready  = advance;
  assign out_valid = s3Valid;
  assign result    = s3Result;
  assign out_tag   = s3Tag;
  assign flags     = s3Flags;

  // ---------------- S1: unpack, special detect, align ----------------
  logic                 signA, signB, swap, anyNan;
  logic                 baseSign, otherSign;
  logic [EXP_W-1:0]     expA, expB, baseExp, otherExp, diffExp;
  logic [EXT_W-1:0]     manA, manB, baseMan, otherMan, alignedMan;
  logic [2*EXT_W-1:0]   alignWide;

  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    signA     = a[W-1];
    signB     = b[W-1] ^ op;
    expA      = a[W-2:MAN_W];
    expB      = b[W-2:MAN_W];
    manA      = (expA == '0) ? '0 : {1'b1, a[MAN_W-1:0], 3'b000};
    manB      = (expB == '0) ? '0 : {1'b1, b[MAN_W-1:0], 3'b000};
    anyNan    = (&expA) | (&expB);
    swap      = expB > expA;
    baseSign  = swap ? signB : signA;
    otherSign = swap ? signA : signB;
    baseExp   = swap ? expB : expA;
    otherExp  = swap ? expA : expB;
    baseMan   = swap ? manB : manA;
    otherMan  = swap ? manA : manB;
    diffExp   = baseExp - otherExp;
    alignWide = {otherMan, {EXT_W{1'b0}}} >> diffExp;
    alignedMan    = alignWide[2*EXT_W-1:EXT_W];
    alignedMan[0] = alignWide[EXT_W] | (|alignWide[EXT_W-1:0]);
    if (32'(diffExp) >= 32'(ALIGN_LIMIT)) begin
      alignedMan    = '0;
      alignedMan[0] = |otherMan;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s2Valid <= 1'b0;
    end else if (advance) begin
      s1Valid <= in_valid;
      s2Valid <= s1Valid;
    end
  end

  // NOTE: datapath registers of S1/S2 are not reset; their valid bits alone gate them.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1Tag       <= in_tag;
      s1Nan       <= anyNan;
      s1BaseSign  <= baseSign;
      s1OtherSign <= otherSign;
      s1Exp       <= baseExp;
      s1BaseMan   <= baseMan;
      s1OtherMan  <= alignedMan;
    end
  end

  // ---------------- S2: signed magnitude add / subtract ----------------
  logic [MAG_W-1:0] addSum, subDiff, subRev, magNext;
  logic             signNext;

  always_comb begin
    addSum   = {1'b0, s1BaseMan} + {1'b0, s1OtherMan};
    subDiff  = {1'b0, s1BaseMan} - {1'b0, s1OtherMan};
    subRev   = {1'b0, s1OtherMan} - {1'b0, s1BaseMan};
    magNext  = addSum;
    signNext = s1BaseSign;
    if (s1BaseSign != s1OtherSign) begin
      // A borrow means the aligned operand was larger (only possible on equal exponents).
      if (subDiff[MAG_W-1]) begin
        magNext  = subRev;
        signNext = s1OtherSign;
      end else begin
        magNext  = subDiff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s2Tag  <= s1Tag;
      s2Nan  <= s1Nan;
      s2Sign <= signNext;
      s2Exp  <= s1Exp;
      s2Mag  <= magNext;
    end
  end

  // ---------------- S3: normalise, truncate, pack ----------------
  int               lead;
  int               expInt;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     packNext;
  logic [3:0]       flagsNext;

  always_comb begin
    lead = 0;
    for (int i = 0; i < EXT_W; i++) begin
      if (s2Mag[i]) lead = i;
    end
    if (s2Mag[MAG_W-1]) begin
      expInt = int'(s2Exp) + 1;
      frac   = MAN_W'(s2Mag >> 4);
    end else begin
      expInt = int'(s2Exp) - (EXT_W - 1 - lead);
      frac   = MAN_W'((s2Mag[EXT_W-1:0] << (EXT_W - 1 - lead)) >> 3);
    end
    packNext  = {s2Sign, EXP_W'(expInt), frac};
    flagsNext = FLAG_NONE;
    if (s2Nan) begin
      packNext  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flagsNext = FLAG_INVALID;
    end else if (s2Mag == '0) begin
      packNext  = '0;
      flagsNext = FLAG_ZERO;
    end else if (expInt >= EXP_MAX) begin
      packNext  = {s2Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flagsNext = FLAG_OVERFLOW;
    end else if (expInt <= 0) begin
      packNext  = {s2Sign, {(W-1){1'b0}}};
      flagsNext = FLAG_UNDERFLOW | FLAG_ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s3Valid  <= 1'b0;
      s3Result <= '0;
      s3Tag    <= '0;
      s3Flags  <= '0;
    end else if (advance) begin
      s3Valid  <= s2Valid;
      s3Result <= packNext;
      s3Tag    <= s2Tag;
      s3Flags  <= flagsNext;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Self-checking bench for fp_add_pipe: directed vectors, stall/reset scenarios and
// randomized traffic compared against an exact round-toward-zero reference model.
module tb_fp_add_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [3:0]  tag;
  } op_t;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic [3:0]  flags;

  int   checks = 0;
  int   failures = 0;
  int   outCount = 0;
  op_t  pend[$];
  exp_t sb[$];

  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact-arithmetic reference: align at 40 extra bits, use ceil of the smaller operand
  // when subtracting, then truncate the exact value to 24 significant bits.
  function automatic logic [35:0] refAdd(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic        sx, sy, sh, xBigger, lost;
    int          ex, ey, eh, el, d, p, e;
    logic [23:0] mx, my, mh, ml;
    logic [71:0] hiV, loFull, loV, sum, norm;
    sx = x[31];
    sy = y[31] ^ sub;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ex == 255 || ey == 255) return {4'b1000, 32'h7FC0_0000};
    mx = (ex == 0) ? 24'd0 : {1'b1, x[22:0]};
    my = (ey == 0) ? 24'd0 : {1'b1, y[22:0]};
    xBigger = (ex > ey) || (ex == ey && mx >= my);
    eh = xBigger ? ex : ey;
    el = xBigger ? ey : ex;
    mh = xBigger ? mx : my;
    ml = xBigger ? my : mx;
    sh = xBigger ? sx : sy;
    d  = eh - el;
    hiV    = 72'(mh) << 40;
    loFull = 72'(ml) << 40;
    if (d > 60) begin
      loV  = '0;
      lost = (ml != 0);
    end else begin
      loV  = loFull >> d;
      lost = ((loV << d) != loFull);
    end
    if (sx == sy) sum = hiV + loV;
    else          sum = hiV - loV - 72'(lost);
    if (sum == 0) return {4'b0001, 32'h0};
    p = 0;
    for (int i = 0; i < 72; i++) if (sum[i]) p = i;
    e    = eh + p - 63;
    norm = sum << (71 - p);
    if (e >= 255) return {4'b0100, sh, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, sh, 31'h0};
    return {4'b0000, sh, 8'(e), norm[70:48]};
  endfunction

  function automatic logic [31:0] randOperand();
    logic [7:0] e;
    int cls;
    cls = $urandom_range(0, 11);
    case (cls)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 4));
      3:       e = 8'($urandom_range(251, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  function automatic op_t randOp();
    op_t o;
    int  eb;
    o.a   = randOperand();
    o.op  = 1'($urandom_range(0, 1));
    o.tag = 4'($urandom);
    case ($urandom_range(0, 4))
      0: o.b = o.a;
      1: o.b = {~o.a[31], o.a[30:0]};
      2: begin
        eb = int'(o.a[30:23]) + int'($urandom_range(0, 6)) - 3;
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
        o.b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      end
      default: o.b = randOperand();
    endcase
    return o;
  endfunction

  task automatic runDirected(input string name, input logic [31:0] x, input logic [31:0] y,
                             input logic sub, input logic [31:0] expRes, input logic [3:0] expFlg,
                             input logic [3:0] tag);
    int lat;
    in_valid = 1'b1; a = x; b = y; op = sub; in_tag = tag; out_ready = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check({name, "_latency"}, lat, 32'd3);
    check({name, "_result"}, result, expRes);
    check({name, "_flags"}, 32'(flags), 32'(expFlg));
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
    tick();
  endtask

  // Drives the pending queue; randomMode randomizes gaps and back-pressure, otherwise
  // out_ready drops for the first two cycles of the first out_valid.
  task automatic runTraffic(input bit randomMode, input int budget);
    int          waited, lowLeft;
    bit          prevStall, firstSeen;
    logic [31:0] heldRes;
    logic [3:0]  heldTag, heldFlg;
    logic [35:0] r;
    exp_t        e;
    op_t         cur;
    waited = 0; lowLeft = 0; prevStall = 0; firstSeen = 0;
    heldRes = '0; heldTag = '0; heldFlg = '0;
    outCount = 0;
    while ((pend.size() > 0 || sb.size() > 0) && waited < budget) begin
      in_valid = (pend.size() > 0) && (!randomMode || $urandom_range(0, 4) != 0);
      if (pend.size() > 0) begin
        a = pend[0].a; b = pend[0].b; op = pend[0].op; in_tag = pend[0].tag;
      end
      if (randomMode) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        if (out_valid && !firstSeen) begin
          firstSeen = 1;
          lowLeft = 2;
        end
        out_ready = (lowLeft == 0);
        if (lowLeft > 0) lowLeft--;
      end
      @(negedge clk);
      check("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prevStall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_result", result, heldRes);
        check("hold_tag", 32'(out_tag), 32'(heldTag));
        check("hold_flags", 32'(flags), 32'(heldFlg));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          outCount++;
          check("stream_result", result, e.res);
          check("stream_flags", 32'(flags), 32'(e.flg));
          check("stream_tag", 32'(out_tag), 32'(e.tag));
        end
      end
      prevStall = out_valid && !out_ready;
      heldRes = result; heldTag = out_tag; heldFlg = flags;
      if (in_valid && in_ready) begin
        cur = pend.pop_front();
        r = refAdd(cur.a, cur.b, cur.op);
        e.res = r[31:0];
        e.flg = r[35:32];
        e.tag = cur.tag;
        sb.push_back(e);
      end
      tick();
      waited++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("drain_within_budget", 32'(waited < budget), 32'd1);
  endtask

  initial begin
    op_t o;
    reset = 1'b1; in_valid = 1'b1; a = 32'h3F80_0000; b = 32'h3F80_0000;
    op = 1'b0; in_tag = 4'hF; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("post_reset_idle", 32'(out_valid), 32'd0);
    end
    tick();

    runDirected("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4'b0000, 4'h1);
    runDirected("one_minus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0001, 4'h2);
    runDirected("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0100, 4'h3);
    runDirected("inf_in_nan", 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b1000, 4'h4);
    runDirected("nan_b", 32'h3F80_0000, 32'h7FC1_2345, 1'b1, 32'h7FC0_0000, 4'b1000, 4'h5);
    runDirected("truncate_add", 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'b0000, 4'h6);
    runDirected("truncate_sub_sticky", 32'h3F80_0000, 32'h0A00_0000, 1'b1, 32'h3F7F_FFFF, 4'b0000, 4'h7);
    runDirected("underflow", 32'h0080_0000, 32'h00C0_0000, 1'b1, 32'h8000_0000, 4'b0011, 4'h8);
    runDirected("zero_operand", 32'h0000_0000, 32'h4040_0000, 1'b0, 32'h4040_0000, 4'b0000, 4'h9);

    // Four back-to-back operations through a two-cycle output stall.
    pend.push_back('{a: 32'h3F80_0000, b: 32'h3F80_0000, op: 1'b0, tag: 4'd1});
    pend.push_back('{a: 32'h4000_0000, b: 32'h3F80_0000, op: 1'b0, tag: 4'd2});
    pend.push_back('{a: 32'h4040_0000, b: 32'h3F80_0000, op: 1'b1, tag: 4'd3});
    pend.push_back('{a: 32'h3F80_0000, b: 32'hBF80_0000, op: 1'b0, tag: 4'd4});
    runTraffic(1'b0, 50);
    check("stall_out_count", outCount, 32'd4);

    // Reset with two operations in flight: neither may ever appear.
    in_valid = 1'b1; a = 32'h4000_0000; b = 32'h4000_0000; op = 1'b0; in_tag = 4'd10;
    out_ready = 1'b1;
    tick();
    in_tag = 4'd11;
    tick();
    reset = 1'b1; in_tag = 4'd12;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_result", result, 32'h0);
    check("midreset_out_tag", 32'(out_tag), 32'd0);
    check("midreset_flags", 32'(flags), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("midreset_flushed", 32'(out_valid), 32'd0);
    end
    tick();
    runDirected("after_reset", 32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 4'b0000, 4'hD);

    // Randomized traffic with random gaps and back-pressure.
    for (int i = 0; i < 400; i++) begin
      o = randOp();
      pend.push_back(o);
    end
    runTraffic(1'b1, 6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored-mantissa field width; operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter TAG_W, default 4, width of the user tag carried alongside each operation.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  operand pair presented.
REQ-007 in_ready  out  1  block accepts the operand pair this cycle.
REQ-008 a, b  in  W each  IEEE-style operands {sign, exponent, mantissa}.
REQ-009 op  in  1  0 = a+b, 1 = a-b.
REQ-010 in_tag  in  TAG_W  user tag.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  consumer accepts the result.
REQ-013 result  out  W  packed sum.
REQ-014 out_tag  out  TAG_W  tag of the operation producing result.
REQ-015 flags  out  4  {invalid, overflow, underflow, zero}.

Function
REQ-016 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-017 Three register stages: S1 unpack/special-detect/align, S2 signed mantissa add/subtract with carry, S3 normalise/pack.
REQ-018 Latency: an operation accepted in cycle N SHALL present out_valid in cycle N+3 when no stall occurs; throughput one op per cycle.
REQ-019 Stall: when out_valid && !out_ready, all stages hold and in_ready SHALL be 0; otherwise in_ready SHALL be 1 (bubbles are not compressed).
REQ-020 While stalled, result, out_tag and flags SHALL remain stable.
REQ-021 Operations SHALL exit in acceptance order; none dropped or duplicated.
REQ-022 op=1 SHALL invert the sign of b before alignment.
REQ-023 Alignment: the operand with the larger exponent (a on tie) is the base; the other's mantissa, with hidden 1 restored, is shifted right by the exponent difference; difference >= MAN_W+3 yields zero plus sticky.
REQ-024 Equal signs: mantissas added, carry-out increments the exponent and shifts right by one.
REQ-025 Unequal signs: smaller magnitude subtracted from larger; result sign = sign of larger-magnitude operand; leading-zero count normalises left with matching exponent decrement.
REQ-026 Rounding: truncation (round toward zero); guard/sticky bits discarded.
REQ-027 Exact cancellation SHALL give +0 (all bits 0) with zero flag set.
REQ-028 Input exponent all-zero SHALL be treated as signed zero (denormals flushed).
REQ-029 Any input with exponent all-ones SHALL produce canonical NaN {0, all-ones exponent, MSB mantissa 1, rest 0} with invalid set; other flags 0.
REQ-030 Normalised exponent >= all-ones SHALL produce signed infinity (mantissa 0) with overflow set.
REQ-031 Normalised exponent <= 0 SHALL produce signed zero with underflow and zero set.
REQ-032 Tag SHALL travel unmodified with its operation.

Reset
REQ-033 reset high at a clock edge SHALL clear all stage valid bits; next cycle out_valid=0, result=0, out_tag=0, flags=0, in_ready=1.
REQ-034 Operations in flight when reset is asserted SHALL be discarded and never emitted; in_valid is ignored in reset cycles.
REQ-035 Reset SHALL take priority over simultaneous transfers in the same cycle.

Verification (EXP_W=8, MAN_W=23)
REQ-036 a=3F800000, b=3F800000, op=0, out_ready=1 -> exactly 3 cycles later result=40000000, flags=0000.
REQ-037 a=3F800000, b=3F800000, op=1 -> result=00000000, flags=0001.
REQ-038 a=7F7FFFFF, b=7F7FFFFF, op=0 -> result=7F800000, flags=0100; a=7F800000, b=3F800000 -> result=7FC00000, flags=1000.
REQ-039 a=3F800000, b=33800000, op=0 -> result=3F800000 (truncated), flags=0000.
REQ-040 Four back-to-back ops, tags 1..4, out_ready low for 2 cycles after first out_valid -> in_ready low during stall, result stable, tags emerge 1,2,3,4 with correct values.
REQ-041 Two ops in flight, reset pulsed one cycle -> out_valid stays 0 thereafter until a new op is accepted, which emerges 3 cycles after acceptance.
